// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream, register-write and reply-transmit signals of the UART command controller.
// The slave modport is the controller side; the master modport is the surrounding logic.
interface uart_cmd_ctrl_if;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        tx_busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        err_chk;
    logic        err_tmo;
    logic [7:0]  err_cnt;

    modport slave (
        input  rx_done, rx_data, tx_busy,
        output wr_en, wr_addr, wr_data, tx_en, tx_data, err_chk, err_tmo, err_cnt
    );

    modport master (
        output rx_done, rx_data, tx_busy,
        input  wr_en, wr_addr, wr_data, tx_en, tx_data, err_chk, err_tmo, err_cnt
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses 5-byte frames (SOF, ADDR, DATA_H, DATA_L, CHK) into register writes and
// answers each complete frame with a one-byte ACK/NAK, guarded by an inter-byte timeout.
module uart_cmd_ctrl #(
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter logic [7:0]  ACK_OK      = 8'h06,
    parameter logic [7:0]  ACK_ERR     = 8'h15,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    uart_cmd_ctrl_if.slave  bus
);
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0, ADDR = 3'd1, DATH = 3'd2, DATL = 3'd3,
        CHK  = 3'd4, EXEC = 3'd5, ACK  = 3'd6
    } state_t;

    state_t          state_r, state_s;
    logic [TW-1:0]   timer_r, timer_s;
    logic            rx_done_d_r;
    logic [7:0]      addr_sh_r, dath_sh_r, datl_sh_r;
    logic            wr_en_r, err_chk_r, err_tmo_r;
    logic [7:0]      wr_addr_r, reply_r, err_cnt_r;
    logic [15:0]     wr_data_r;
    logic            byte_vld_s, tmo_hit_s, match_s;
    logic            tmo_s, chk_done_s, tx_start_s;

    function automatic state_t field_next(input state_t cur);
        case (cur)
            ADDR:    field_next = DATH;
            DATH:    field_next = DATL;
            DATL:    field_next = CHK;
            default: field_next = EXEC;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt == 8'hFF) sat_inc = cnt;
        else              sat_inc = cnt + 8'd1;
    endfunction

    assign byte_vld_s = bus.rx_done & ~rx_done_d_r;
    assign tmo_hit_s  = (timer_r == TW'(TIMEOUT_CYC - 32'd1));
    assign match_s    = (bus.rx_data == (addr_sh_r ^ dath_sh_r ^ datl_sh_r));

    // Next-state, event decode and inter-byte timer
    always_comb begin
        state_s    = state_r;
        tmo_s      = 1'b0;
        chk_done_s = 1'b0;
        tx_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (byte_vld_s && (bus.rx_data == SOF_BYTE)) state_s = ADDR;
                else                                         state_s = IDLE;
            end
            ADDR, DATH, DATL, CHK: begin
                // A byte arriving on the timeout cycle still counts
                if (byte_vld_s) begin
                    state_s    = field_next(state_r);
                    chk_done_s = (state_r == CHK);
                end else if (tmo_hit_s) begin
                    state_s = IDLE;
                    tmo_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            EXEC: state_s = ACK;
            ACK: begin
                if (!bus.tx_busy) begin
                    tx_start_s = 1'b1;
                    state_s    = IDLE;
                end else if (tmo_hit_s) begin
                    state_s = IDLE;
                    tmo_s   = 1'b1;
                end else begin
                    state_s = ACK;
                end
            end
            default: state_s = IDLE;
        endcase

        if (byte_vld_s || (state_s != state_r))
            timer_s = {TW{1'b0}};
        else if (state_r inside {ADDR, DATH, DATL, CHK, ACK})
            timer_s = timer_r + TW'(1);
        else
            timer_s = {TW{1'b0}};
    end

    // State, shadows, write outputs, error pulses and counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= IDLE;
            timer_r     <= {TW{1'b0}};
            rx_done_d_r <= 1'b1;
            addr_sh_r   <= 8'h00;
            dath_sh_r   <= 8'h00;
            datl_sh_r   <= 8'h00;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= 8'h00;
            wr_data_r   <= 16'h0000;
            reply_r     <= 8'h00;
            err_chk_r   <= 1'b0;
            err_tmo_r   <= 1'b0;
            err_cnt_r   <= 8'h00;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            rx_done_d_r <= bus.rx_done;
            wr_en_r     <= 1'b0;
            err_chk_r   <= 1'b0;
            err_tmo_r   <= tmo_s;
            if (byte_vld_s) begin
                case (state_r)
                    ADDR:    addr_sh_r <= bus.rx_data;
                    DATH:    dath_sh_r <= bus.rx_data;
                    DATL:    datl_sh_r <= bus.rx_data;
                    default: ;
                endcase
            end
            if (chk_done_s) begin
                if (match_s) begin
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= addr_sh_r;
                    wr_data_r <= {dath_sh_r, datl_sh_r};
                    reply_r   <= ACK_OK;
                end else begin
                    err_chk_r <= 1'b1;
                    reply_r   <= ACK_ERR;
                end
            end
            if ((chk_done_s && !match_s) || tmo_s)
                err_cnt_r <= sat_inc(err_cnt_r);
        end
    end

    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
    // The reply start must coincide with the first idle-transmitter cycle, so it is decoded from state
    assign bus.tx_en   = tx_start_s & ~sys_rst;
    assign bus.tx_data = reply_r;
    assign bus.err_chk = err_chk_r;
    assign bus.err_tmo = err_tmo_r;
    assign bus.err_cnt = err_cnt_r;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected write/error/reply events,
// a negedge monitor pops and compares them as the controller produces them.
module tb_uart_cmd_ctrl;
    localparam int unsigned TMO = 1000;
    localparam logic [1:0] K_WR = 2'd0, K_CHK = 2'd1, K_TMO = 2'd2, K_TX = 2'd3;

    logic clk = 1'b0;
    logic rst;
    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [7:0]  txb;
        logic [7:0]  cnt;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tx_seen = 0;
    logic [7:0]  m_cnt = 8'h00;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] txb);
        ev_t e;
        e.kind = kind; e.addr = m_addr; e.data = m_data; e.txb = txb; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Hand-computed verdicts: good frame -> write + ACK, bad checksum -> error + NAK
    task automatic exp_good(input logic [7:0] a, input logic [15:0] d);
        m_addr = a; m_data = d;
        push_ev(K_WR, 8'h00);
        push_ev(K_TX, 8'h06);
    endtask

    task automatic exp_bad();
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        push_ev(K_CHK, 8'h00);
        push_ev(K_TX, 8'h15);
    endtask

    task automatic exp_tmo();
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        push_ev(K_TMO, 8'h00);
    endtask

    task automatic mon(input logic [1:0] kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got kind %0d, expected no event (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.wr_data), 32'(e.data));
            chk("err_cnt", 32'(bus.err_cnt), 32'(e.cnt));
            if (kind == K_TX) chk("tx_data", 32'(bus.tx_data), 32'(e.txb));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en)   mon(K_WR);
            if (bus.err_chk) mon(K_CHK);
            if (bus.err_tmo) mon(K_TMO);
            if (bus.tx_en) begin
                tx_seen++;
                mon(K_TX);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        chk({tag, "_tx_en"},   32'(bus.tx_en),   32'd0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_err_chk"}, 32'(bus.err_chk), 32'd0);
        chk({tag, "_err_tmo"}, 32'(bus.err_tmo), 32'd0);
        chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                              input logic [7:0] c, input int hold);
        send_byte(8'hA5, hold);
        send_byte(a, hold);
        send_byte(dh, hold);
        send_byte(dl, hold);
        send_byte(c, hold);
        repeat (6) @(posedge clk);
    endtask

    initial begin
        int tx_before;
        rst = 1'b1;
        bus.rx_done = 1'b1;
        bus.rx_data = 8'hA5;
        bus.tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // rx_done held high across reset release must not be taken as a SOF byte
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        bus.rx_done = 1'b0;
        repeat (2) @(posedge clk);

        exp_good(8'h12, 16'h3456);
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1);

        exp_bad();
        send_frame(8'h12, 8'h34, 8'h56, 8'h00, 1);

        // Long rx_done levels plus junk bytes before SOF
        send_byte(8'h00, 300);
        send_byte(8'hFF, 300);
        exp_good(8'hAB, 16'hCDEF);
        send_frame(8'hAB, 8'hCD, 8'hEF, 8'h89, 300);

        // Truncated frame times out, then a good frame parses normally
        exp_tmo();
        send_byte(8'hA5, 1);
        send_byte(8'h12, 1);
        repeat (TMO + 100) @(posedge clk);
        exp_good(8'h01, 16'h0203);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 1);

        // Transmitter busy for 50 cycles: reply starts right after it frees up
        #1 bus.tx_busy = 1'b1;
        tx_before = tx_seen;
        exp_good(8'h11, 16'h2244);
        send_frame(8'h11, 8'h22, 8'h44, 8'h77, 1);
        repeat (50) @(posedge clk);
        chk("tx_held_while_busy", 32'(tx_seen), 32'(tx_before));
        #1 bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("tx_en_after_busy", 32'(bus.tx_en), 32'd1);
        repeat (4) @(posedge clk);

        // Transmitter busy past the timeout: reply abandoned
        #1 bus.tx_busy = 1'b1;
        exp_good(8'h21, 16'h4365);
        exp_q.delete(exp_q.size() - 1);
        exp_tmo();
        tx_before = tx_seen;
        send_frame(8'h21, 8'h43, 8'h65, 8'h07, 1);
        repeat (TMO + 100) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
        repeat (5) @(posedge clk);
        chk("no_tx_after_ack_tmo", 32'(tx_seen), 32'(tx_before));

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            exp_bad();
            send_frame(8'h00, 8'h00, 8'h00, 8'h01, 1);
        end
        chk("err_cnt_saturated", 32'(bus.err_cnt), 32'hFF);

        // Reset mid-frame abandons the frame and clears all outputs
        send_byte(8'hA5, 1);
        send_byte(8'h12, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midrst");
        @(posedge clk); #1 rst = 1'b0;
        m_cnt = 8'h00; m_addr = 8'h00; m_data = 16'h0000;
        repeat (2) @(posedge clk);
        exp_good(8'h12, 16'h3456);
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        chk("events_outstanding", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
